// File: rtl/hack_multicycle_cpu_pkg.sv
// Shared types and instruction field positions
// for the multi-cycle Hack CPU.
package hack_cpu_pkg;

  typedef enum logic [4:0] {
    FETCH    = 5'b00001,
    EXECUTE  = 5'b00010,
    SETXY    = 5'b00100,
    SET_DEST = 5'b01000,
    SET_PC   = 5'b10000
  } state_e;

  localparam int C_BIT   = 15;
  localparam int A_BIT   = 12;
  localparam int COMP_HI = 11;
  localparam int COMP_LO = 6;
  localparam int DEST_A  = 5;
  localparam int DEST_D  = 4;
  localparam int DEST_M  = 3;
  localparam int J_LT    = 2;
  localparam int J_EQ    = 1;
  localparam int J_GT    = 0;

endpackage

// File: rtl/hack_multicycle_cpu_if.sv
// Instruction ROM and data memory bus
// between the Hack CPU and its memories.
interface hack_multicycle_cpu_if;
  logic [15:0] inM;
  logic [15:0] romOut;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  modport master (
    input  inM, romOut,
    output outM, writeM, addressM, pc
  );

  modport slave (
    output inM, romOut,
    input  outM, writeM, addressM, pc
  );
endinterface

// File: rtl/hack_multicycle_cpu_alu.sv
// Combinational 16-bit Hack ALU with
// zero and negative flags.
module hack_alu (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);
  logic [15:0] x1, x2, y1, y2, o;

  assign x1  = zx ? 16'h0000 : x;
  assign x2  = nx ? ~x1 : x1;
  assign y1  = zy ? 16'h0000 : y;
  assign y2  = ny ? ~y1 : y1;
  assign o   = f ? (x2 + y2) : (x2 & y2);
  assign out = no ? ~o : o;
  assign zr  = (out == 16'h0000);
  assign ng  = out[15];
endmodule

// File: rtl/hack_multicycle_cpu.sv
// Multi-cycle Hack CPU: 3-cycle A-instructions,
// 5-cycle C-instructions, registered memory bus.
module hack_multicycle_cpu
  import hack_cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  hack_multicycle_cpu_if.master  bus
);
  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] outm_q, outm_d;
  logic [14:0] addr_q, addr_d;
  logic [14:0] pc_q, pc_d;
  logic [14:0] tgt_q, tgt_d;
  logic        wr_q, wr_d;
  logic        jmp_q, jmp_d;

  logic [15:0] alu_out;
  logic        alu_zr, alu_ng;
  logic        jump;

  hack_alu u_alu (
    .x   (x_q),
    .y   (y_q),
    .zx  (instr_q[COMP_HI]),
    .nx  (instr_q[COMP_HI-1]),
    .zy  (instr_q[COMP_HI-2]),
    .ny  (instr_q[COMP_HI-3]),
    .f   (instr_q[COMP_LO+1]),
    .no  (instr_q[COMP_LO]),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  assign jump = instr_q[C_BIT] &
    ((instr_q[J_LT] & alu_ng) |
     (instr_q[J_EQ] & alu_zr) |
     (instr_q[J_GT] & ~alu_zr & ~alu_ng));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    a_d     = a_q;
    d_d     = d_q;
    x_d     = x_q;
    y_d     = y_q;
    outm_d  = outm_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    jmp_d   = jmp_q;
    wr_d    = 1'b0;
    case (state_q)
      FETCH: begin
        instr_d = bus.romOut;
        state_d = EXECUTE;
      end
      EXECUTE: begin
        if (!instr_q[C_BIT]) begin
          a_d     = instr_q;
          jmp_d   = 1'b0;
          state_d = SET_PC;
        end else begin
          addr_d  = a_q[14:0];
          state_d = SETXY;
        end
      end
      SETXY: begin
        x_d     = d_q;
        y_d     = instr_q[A_BIT] ? bus.inM : a_q;
        state_d = SET_DEST;
      end
      SET_DEST: begin
        if (instr_q[DEST_A]) a_d = alu_out;
        if (instr_q[DEST_D]) d_d = alu_out;
        if (instr_q[DEST_M]) begin
          outm_d = alu_out;
          wr_d   = 1'b1;
        end
        // target is A before this instruction's own update
        jmp_d   = jump;
        tgt_d   = a_q[14:0];
        state_d = SET_PC;
      end
      SET_PC: begin
        pc_d    = jmp_q ? tgt_q : pc_q + 15'd1;
        state_d = FETCH;
      end
      default: begin
        // corrupted state code recovers like reset
        state_d = FETCH;
        instr_d = '0;
        a_d     = '0;
        d_d     = '0;
        x_d     = '0;
        y_d     = '0;
        outm_d  = '0;
        addr_d  = '0;
        pc_d    = '0;
        tgt_d   = '0;
        jmp_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      instr_q <= '0;
      a_q     <= '0;
      d_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      outm_q  <= '0;
      addr_q  <= '0;
      pc_q    <= '0;
      tgt_q   <= '0;
      wr_q    <= 1'b0;
      jmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      a_q     <= a_d;
      d_q     <= d_d;
      x_q     <= x_d;
      y_q     <= y_d;
      outm_q  <= outm_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      wr_q    <= wr_d;
      jmp_q   <= jmp_d;
    end
  end

  assign bus.outM     = outm_q;
  assign bus.writeM   = wr_q;
  assign bus.addressM = addr_q;
  assign bus.pc       = pc_q;

endmodule

// File: tb/tb_hack_multicycle_cpu.sv
// Directed-program bench for the multi-cycle
// Hack CPU with ROM and RAM models.
module tb_hack_multicycle_cpu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int w0;

  logic [15:0] rom [0:32767];
  logic [15:0] ram [0:32767];

  hack_multicycle_cpu_if bus ();

  hack_multicycle_cpu dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.romOut = rom[bus.pc];
  assign bus.inM    = ram[bus.addressM];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.writeM) ram[bus.addressM] <= bus.outM;

  always @(negedge clk)
    if (bus.writeM) wr_cnt++;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32768; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  initial begin
    // A then C: D=A, M=D
    clear_mem();
    rom[0] = 16'h0005;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0002;
    rom[3] = 16'hE308;
    do_reset();
    check("rst_pc", bus.pc, 0);
    check("rst_wr", bus.writeM, 0);
    check("rst_addr", bus.addressM, 0);
    check("rst_outm", bus.outM, 0);
    step(2);
    check("a_lat2", bus.pc, 0);
    step(1);
    check("a_lat3", bus.pc, 1);
    step(4);
    check("c_lat4", bus.pc, 1);
    step(1);
    check("c_lat5", bus.pc, 2);
    step(3);
    check("pc3", bus.pc, 3);
    w0 = wr_cnt;
    step(4);
    check("md_wr", bus.writeM, 1);
    check("md_addr", bus.addressM, 2);
    check("md_outm", bus.outM, 5);
    check("md_pc", bus.pc, 3);
    step(1);
    check("md_wr_off", bus.writeM, 0);
    check("pc4", bus.pc, 4);
    check("md_ram", ram[2], 5);
    step(1);
    check("md_pulse", 16'(wr_cnt - w0), 1);

    // reset while M=D sits in SET_DEST
    ram[2] = 16'h0000;
    do_reset();
    step(11);
    check("mr_pc", bus.pc, 3);
    step(3);
    check("mr_addr", bus.addressM, 2);
    w0 = wr_cnt;
    do_reset();
    check("mr_rst_pc", bus.pc, 0);
    check("mr_rst_wr", bus.writeM, 0);
    check("mr_rst_addr", bus.addressM, 0);
    check("mr_rst_outm", bus.outM, 0);
    step(1);
    check("mr_nowrite", 16'(wr_cnt - w0), 0);
    check("mr_ram", ram[2], 0);
    step(2);
    check("mr_refetch", bus.pc, 1);

    // M operand, AM destination
    clear_mem();
    rom[0] = 16'h0007;
    rom[1] = 16'hEE90;
    rom[2] = 16'hFDE8;
    rom[3] = 16'hEC10;
    ram[7] = 16'h0010;
    do_reset();
    step(8);
    check("am_pc", bus.pc, 2);
    step(4);
    check("am_wr", bus.writeM, 1);
    check("am_addr", bus.addressM, 7);
    check("am_outm", bus.outM, 16'h0011);
    step(1);
    check("am_pc3", bus.pc, 3);
    check("am_ram", ram[7], 16'h0011);
    step(2);
    check("am_newa", bus.addressM, 16'h0011);

    // unconditional jump
    clear_mem();
    rom[0] = 16'h0100;
    rom[1] = 16'hEA87;
    do_reset();
    w0 = wr_cnt;
    step(3);
    check("jmp_pc1", bus.pc, 1);
    step(5);
    check("jmp_pc", bus.pc, 16'h0100);
    check("jmp_nowr", 16'(wr_cnt - w0), 0);

    // JEQ taken with D=0
    clear_mem();
    rom[0] = 16'hEA90;
    rom[1] = 16'h0020;
    rom[2] = 16'hE302;
    do_reset();
    step(12);
    check("jeq_t_pre", bus.pc, 2);
    step(1);
    check("jeq_t", bus.pc, 16'h0020);

    // JEQ not taken with D=3
    clear_mem();
    rom[0] = 16'h0003;
    rom[1] = 16'hEC10;
    rom[2] = 16'h0020;
    rom[3] = 16'hE302;
    do_reset();
    step(16);
    check("jeq_nt", bus.pc, 4);

    // JLT taken with D=0x8000
    clear_mem();
    rom[0] = 16'h7FFF;
    rom[1] = 16'hEC10;
    rom[2] = 16'hE7D0;
    rom[3] = 16'h0020;
    rom[4] = 16'hE304;
    do_reset();
    step(21);
    check("jlt_t", bus.pc, 16'h0020);

    // JGT not taken with D=0
    clear_mem();
    rom[0] = 16'hEA90;
    rom[1] = 16'h0020;
    rom[2] = 16'hE301;
    do_reset();
    step(13);
    check("jgt_nt", bus.pc, 3);

    // old A as target, ALU wraps to zero
    clear_mem();
    rom[0]     = 16'h0030;
    rom[1]     = 16'hFDEF;
    rom[16'h30] = 16'hEC10;
    ram[16'h30] = 16'hFFFF;
    do_reset();
    step(7);
    check("old_wr", bus.writeM, 1);
    check("old_addr", bus.addressM, 16'h0030);
    check("old_outm", bus.outM, 16'h0000);
    step(1);
    check("old_pc", bus.pc, 16'h0030);
    step(2);
    check("old_newa", bus.addressM, 16'h0000);

    // pc increment wraps at the top of ROM
    clear_mem();
    rom[0]          = 16'h7FFF;
    rom[1]          = 16'hEA87;
    rom[15'h7FFF]   = 16'h0001;
    do_reset();
    step(8);
    check("wrap_top", bus.pc, 16'h7FFF);
    step(3);
    check("wrap_zero", bus.pc, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
